pkt_out_sched: RTL and testbench

Output scheduler that shares the single UM→CDP transmit path (rule FIFO plus 139-bit packet bus) between two upstream packet sources, each with a show-ahead packet FIFO and a 1-bit verdict FIFO (1 = forward, 0 = drop). It arbitrates round-robin per packet, writes one egress rule per forwarded packet, waits for `cdp2um_tx_enable`, streams the packet, and silently drains dropped packets. It sits between the parser/uniMon verdict path and the CDP interface, replacing ad-hoc per-path output FSMs.

---
 rtl/pkt_out_sched.sv | 151 +++++++++++++++
 tb/tb_pkt_out_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_out_sched.sv
// pkt_out_sched: shares the single rule FIFO + packet bus toward the CDP
// between two upstream packet sources. Round-robin per packet; forwarded
// packets get one egress rule then stream once tx_enable is seen, dropped
// packets are drained without touching the CDP side.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate between eligible sources, pop verdict on grant
// RULE    | egress rule write strobe is on the bus this cycle
// WAIT_TX | rule written, holding until the CDP can take the packet
// SEND    | popping selected packet FIFO onto um2cdp_data until tail
// DROP    | popping selected packet FIFO with no output until tail
module pkt_out_sched #(
  parameter int         RULE_THRESH  = 30,
  parameter logic [3:0] EGRESS_P0    = 4'd2,
  parameter logic [3:0] EGRESS_OTHER = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         src0_pkt_empty,
  input  logic [138:0] src0_pkt_q,
  output logic         src0_pkt_rdreq,
  input  logic         src0_vd_empty,
  input  logic         src0_vd_q,
  output logic         src0_vd_rdreq,
  input  logic         src1_pkt_empty,
  input  logic [138:0] src1_pkt_q,
  output logic         src1_pkt_rdreq,
  input  logic         src1_vd_empty,
  input  logic         src1_vd_q,
  output logic         src1_vd_rdreq,
  input  logic [4:0]   cdp2um_rule_usedw,
  output logic         um2cdp_rule_wrreq,
  output logic [29:0]  um2cdp_rule,
  input  logic         cdp2um_tx_enable,
  output logic         um2cdp_data_valid,
  output logic [138:0] um2cdp_data,
  output logic [31:0]  fwd_pkt_cnt,
  output logic [31:0]  drop_pkt_cnt
);

  typedef enum logic [2:0] {IDLE, RULE, WAIT_TX, SEND, DROP} state_t;

  localparam logic [5:0] THRESH    = 6'(RULE_THRESH);
  localparam logic [2:0] CODE_TAIL = 3'b110;

  state_t       state, state_nxt;
  logic         sel, last;
  logic         rule_ok, elig0, elig1;
  logic         grant, gnt_idx, gnt_vd;
  logic [138:0] gnt_q, sel_q;
  logic         sel_empty, sel_tail, pop;
  logic [3:0]   egress;

  // A full rule FIFO only blocks forwards; drops never need a rule slot.
  assign rule_ok = ({1'b0, cdp2um_rule_usedw} < THRESH);
  assign elig0   = !src0_vd_empty && !src0_pkt_empty && (!src0_vd_q || rule_ok);
  assign elig1   = !src1_vd_empty && !src1_pkt_empty && (!src1_vd_q || rule_ok);

  // Round-robin grant, only evaluated while idle
  always_comb begin
    grant   = 1'b0;
    gnt_idx = 1'b0;
    if (state == IDLE) begin
      if (elig0 && elig1) begin
        grant   = 1'b1;
        gnt_idx = ~last;
      end else if (elig0) begin
        grant   = 1'b1;
      end else if (elig1) begin
        grant   = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  assign gnt_q  = gnt_idx ? src1_pkt_q : src0_pkt_q;
  assign gnt_vd = gnt_idx ? src1_vd_q  : src0_vd_q;
  assign egress = (gnt_q[131:128] == 4'd0) ? EGRESS_P0 : EGRESS_OTHER;

  assign sel_q     = sel ? src1_pkt_q     : src0_pkt_q;
  assign sel_empty = sel ? src1_pkt_empty : src0_pkt_empty;
  assign sel_tail  = (sel_q[138:136] == CODE_TAIL);
  assign pop       = ((state == SEND) || (state == DROP)) && !sel_empty;

  assign src0_pkt_rdreq = pop && !sel;
  assign src1_pkt_rdreq = pop &&  sel;
  assign src0_vd_rdreq  = grant && !gnt_idx;
  assign src1_vd_rdreq  = grant &&  gnt_idx;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (grant) state_nxt = gnt_vd ? RULE : DROP;
      RULE:       state_nxt = WAIT_TX;
      WAIT_TX:    if (cdp2um_tx_enable) state_nxt = SEND;
      SEND, DROP: if (pop && sel_tail) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register plus granted/last-granted source bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel  <= gnt_idx;
        last <= gnt_idx;
      end
    end
  end

  // Rule strobe lands the cycle after grant; head word is still unpopped then
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      um2cdp_rule_wrreq <= 1'b0;
      um2cdp_rule       <= 30'b0;
    end else begin
      um2cdp_rule_wrreq <= grant && gnt_vd;
      if (grant && gnt_vd) um2cdp_rule <= {26'b0, egress};
    end
  end

  // Register each popped word of a forwarded packet onto the CDP bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      um2cdp_data_valid <= 1'b0;
      um2cdp_data       <= 139'b0;
    end else begin
      um2cdp_data_valid <= (state == SEND) && pop;
      if ((state == SEND) && pop) um2cdp_data <= sel_q;
    end
  end

  // Packet statistics, counted on the tail pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_pkt_cnt  <= 32'b0;
      drop_pkt_cnt <= 32'b0;
    end else if (pop && sel_tail) begin
      if (state == SEND) fwd_pkt_cnt  <= fwd_pkt_cnt + 32'd1;
      else               drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pkt_out_sched.sv
// Bench for pkt_out_sched: show-ahead FIFO models feed both sources, a
// monitor captures rule writes, data words and grants, and each test task
// compares those captures against expectations queued at stimulus time.
module tb_pkt_out_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         src0_pkt_empty, src1_pkt_empty;
  logic [138:0] src0_pkt_q, src1_pkt_q;
  logic         src0_pkt_rdreq, src1_pkt_rdreq;
  logic         src0_vd_empty, src1_vd_empty;
  logic         src0_vd_q, src1_vd_q;
  logic         src0_vd_rdreq, src1_vd_rdreq;
  logic [4:0]   cdp2um_rule_usedw;
  logic         um2cdp_rule_wrreq;
  logic [29:0]  um2cdp_rule;
  logic         cdp2um_tx_enable;
  logic         um2cdp_data_valid;
  logic [138:0] um2cdp_data;
  logic [31:0]  fwd_pkt_cnt, drop_pkt_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int pops0 = 0, pops1 = 0, bad_pop = 0;
  int exp_fwd = 0, exp_drop = 0;

  logic [138:0] pq0[$], pq1[$];
  logic         vq0[$], vq1[$];
  logic [138:0] exp_data[$], obs_data[$];
  logic [29:0]  exp_rule[$], obs_rule[$];
  int           obs_data_cyc[$], obs_rule_cyc[$], obs_grant[$], obs_grant_cyc[$];

  pkt_out_sched dut (
    .clk(clk), .reset(reset),
    .src0_pkt_empty(src0_pkt_empty), .src0_pkt_q(src0_pkt_q), .src0_pkt_rdreq(src0_pkt_rdreq),
    .src0_vd_empty(src0_vd_empty), .src0_vd_q(src0_vd_q), .src0_vd_rdreq(src0_vd_rdreq),
    .src1_pkt_empty(src1_pkt_empty), .src1_pkt_q(src1_pkt_q), .src1_pkt_rdreq(src1_pkt_rdreq),
    .src1_vd_empty(src1_vd_empty), .src1_vd_q(src1_vd_q), .src1_vd_rdreq(src1_vd_rdreq),
    .cdp2um_rule_usedw(cdp2um_rule_usedw), .um2cdp_rule_wrreq(um2cdp_rule_wrreq),
    .um2cdp_rule(um2cdp_rule), .cdp2um_tx_enable(cdp2um_tx_enable),
    .um2cdp_data_valid(um2cdp_data_valid), .um2cdp_data(um2cdp_data),
    .fwd_pkt_cnt(fwd_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // show-ahead FIFO models: head visible 1ns after each edge, pops on rdreq
  always begin
    src0_pkt_empty = (pq0.size() == 0);
    src0_pkt_q     = (pq0.size() == 0) ? '0 : pq0[0];
    src1_pkt_empty = (pq1.size() == 0);
    src1_pkt_q     = (pq1.size() == 0) ? '0 : pq1[0];
    src0_vd_empty  = (vq0.size() == 0);
    src0_vd_q      = (vq0.size() == 0) ? 1'b0 : vq0[0];
    src1_vd_empty  = (vq1.size() == 0);
    src1_vd_q      = (vq1.size() == 0) ? 1'b0 : vq1[0];
    @(posedge clk);
    if (reset) begin
      if (src0_pkt_rdreq) begin
        if (pq0.size() == 0) bad_pop++; else begin void'(pq0.pop_front()); pops0++; end
      end
      if (src1_pkt_rdreq) begin
        if (pq1.size() == 0) bad_pop++; else begin void'(pq1.pop_front()); pops1++; end
      end
      if (src0_vd_rdreq) begin
        if (vq0.size() == 0) bad_pop++; else void'(vq0.pop_front());
      end
      if (src1_vd_rdreq) begin
        if (vq1.size() == 0) bad_pop++; else void'(vq1.pop_front());
      end
    end
    #1;
  end

  // output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (um2cdp_data_valid) begin obs_data.push_back(um2cdp_data); obs_data_cyc.push_back(cycle); end
      if (um2cdp_rule_wrreq) begin obs_rule.push_back(um2cdp_rule); obs_rule_cyc.push_back(cycle); end
      if (src0_vd_rdreq) begin obs_grant.push_back(0); obs_grant_cyc.push_back(cycle); end
      if (src1_vd_rdreq) begin obs_grant.push_back(1); obs_grant_cyc.push_back(cycle); end
    end
  end

  function automatic logic [138:0] mk(input int src, input int pkt, input int idx, input int len,
                                      input logic [3:0] port);
    logic [138:0] w;
    w = '0;
    if (idx == len - 1)  w[138:136] = 3'b110;
    else if (idx == 0)   w[138:136] = 3'b101;
    else                 w[138:136] = 3'b100;
    w[131:128] = port;
    w[127:0]   = {32'(src), 32'(pkt), 32'(idx), $urandom()};
    return w;
  endfunction

  task automatic push_pkt(input int src, input int pkt, input int len, input logic [3:0] port,
                          input logic vd);
    logic [138:0] w;
    for (int i = 0; i < len; i++) begin
      w = mk(src, pkt, i, len, port);
      if (src == 0) pq0.push_back(w); else pq1.push_back(w);
      if (vd) exp_data.push_back(w);
    end
    if (src == 0) vq0.push_back(vd); else vq1.push_back(vd);
    if (vd) exp_rule.push_back({26'b0, (port == 4'd0) ? 4'd2 : 4'd1});
  endtask

  task automatic clear_sb;
    exp_data.delete(); obs_data.delete(); obs_data_cyc.delete();
    exp_rule.delete(); obs_rule.delete(); obs_rule_cyc.delete();
    obs_grant.delete(); obs_grant_cyc.delete();
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    pq0.delete(); pq1.delete(); vq0.delete(); vq1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_sb();
    exp_fwd = 0;
    exp_drop = 0;
  endtask

  task automatic wait_counts(input int budget);
    for (int i = 0; i < budget && !(fwd_pkt_cnt == 32'(exp_fwd) && drop_pkt_cnt == 32'(exp_drop)); i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({um2cdp_rule_wrreq, um2cdp_data_valid, src0_pkt_rdreq, src1_pkt_rdreq, src0_vd_rdreq, src1_vd_rdreq} !== 6'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 000000",
        {um2cdp_rule_wrreq, um2cdp_data_valid, src0_pkt_rdreq, src1_pkt_rdreq, src0_vd_rdreq, src1_vd_rdreq});
    end
    vectors++;
    if (um2cdp_rule !== 30'b0) begin miscompares++; $display("FAIL reset_rule: got %h want 0", um2cdp_rule); end
    vectors++;
    if (um2cdp_data !== 139'b0) begin miscompares++; $display("FAIL reset_data: got %h want 0", um2cdp_data); end
    vectors++;
    if (fwd_pkt_cnt !== 32'd0 || drop_pkt_cnt !== 32'd0) begin
      miscompares++; $display("FAIL reset_counts: got %0d/%0d want 0/0", fwd_pkt_cnt, drop_pkt_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fwd;
    int p0, p1;
    clear_sb();
    cdp2um_tx_enable = 1'b1;
    p0 = pops0; p1 = pops1;
    push_pkt(0, 0, 4, 4'd0, 1'b1);
    exp_fwd++;
    wait_counts(100);
    vectors++;
    if (fwd_pkt_cnt !== 32'(exp_fwd)) begin miscompares++; $display("FAIL fwd1_count: got %0d want %0d", fwd_pkt_cnt, exp_fwd); end
    vectors++;
    if (obs_rule.size() != 1 || obs_rule[0] !== 30'd2) begin
      miscompares++; $display("FAIL fwd1_rule: got %0d rules first %0d want 1 rule 2", obs_rule.size(), obs_rule.size() ? obs_rule[0] : 30'd0);
    end
    vectors++;
    if (obs_data.size() != exp_data.size()) begin
      miscompares++; $display("FAIL fwd1_data_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end else foreach (exp_data[i]) begin
      vectors++;
      if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL fwd1_word[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
    end
    if (obs_grant_cyc.size() == 1 && obs_rule_cyc.size() == 1 && obs_data_cyc.size() == 4) begin
      vectors++;
      if (obs_rule_cyc[0] - obs_grant_cyc[0] != 1) begin
        miscompares++; $display("FAIL fwd1_rule_latency: got %0d want 1", obs_rule_cyc[0] - obs_grant_cyc[0]);
      end
      vectors++;
      if (obs_data_cyc[0] - obs_grant_cyc[0] != 4 || obs_data_cyc[3] - obs_data_cyc[0] != 3) begin
        miscompares++; $display("FAIL fwd1_data_timing: got first %0d span %0d want 4 3",
          obs_data_cyc[0] - obs_grant_cyc[0], obs_data_cyc[3] - obs_data_cyc[0]);
      end
    end else begin
      vectors++; miscompares++;
      $display("FAIL fwd1_events: got grants %0d rules %0d words %0d want 1 1 4", obs_grant_cyc.size(), obs_rule_cyc.size(), obs_data_cyc.size());
    end
    vectors++;
    if (pops0 - p0 != 4 || pops1 != p1 || pq0.size() != 0) begin
      miscompares++; $display("FAIL fwd1_pops: got %0d/%0d left %0d want 4/0 left 0", pops0 - p0, pops1 - p1, pq0.size());
    end
  endtask

  task automatic test_round_robin;
    int lens0[3] = '{2, 1, 4};
    int lens1[3] = '{3, 2, 1};
    int p0, p1;
    apply_reset();
    cdp2um_tx_enable = 1'b1;
    p0 = pops0; p1 = pops1;
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 10 + k, lens0[k], 4'd3, 1'b1);
      push_pkt(1, 20 + k, lens1[k], 4'd3, 1'b1);
    end
    exp_fwd = 6;
    wait_counts(400);
    vectors++;
    if (fwd_pkt_cnt !== 32'd6) begin miscompares++; $display("FAIL rr_count: got %0d want 6", fwd_pkt_cnt); end
    vectors++;
    if (obs_grant.size() != 6) begin
      miscompares++; $display("FAIL rr_grant_count: got %0d want 6", obs_grant.size());
    end else for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs_grant[i] != (i % 2)) begin miscompares++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, obs_grant[i], i % 2); end
    end
    vectors++;
    if (obs_rule.size() != 6) begin
      miscompares++; $display("FAIL rr_rule_count: got %0d want 6", obs_rule.size());
    end else foreach (obs_rule[i]) begin
      vectors++;
      if (obs_rule[i] !== 30'd1) begin miscompares++; $display("FAIL rr_rule[%0d]: got %0d want 1", i, obs_rule[i]); end
    end
    vectors++;
    if (obs_data.size() != exp_data.size()) begin
      miscompares++; $display("FAIL rr_data_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end else foreach (exp_data[i]) begin
      vectors++;
      if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL rr_word[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
    end
    vectors++;
    if (pops0 - p0 != 7 || pops1 - p1 != 6) begin
      miscompares++; $display("FAIL rr_pops: got %0d/%0d want 7/6", pops0 - p0, pops1 - p1);
    end
  endtask

  task automatic test_drop;
    int p0, p1;
    clear_sb();
    p0 = pops0; p1 = pops1;
    push_pkt(1, 30, 5, 4'd2, 1'b0);
    exp_drop++;
    wait_counts(100);
    vectors++;
    if (drop_pkt_cnt !== 32'(exp_drop) || fwd_pkt_cnt !== 32'(exp_fwd)) begin
      miscompares++; $display("FAIL drop_count: got %0d/%0d want %0d/%0d", drop_pkt_cnt, fwd_pkt_cnt, exp_drop, exp_fwd);
    end
    vectors++;
    if (obs_rule.size() != 0 || obs_data.size() != 0) begin
      miscompares++; $display("FAIL drop_outputs: got %0d rules %0d words want 0 0", obs_rule.size(), obs_data.size());
    end
    vectors++;
    if (pops1 - p1 != 5 || pops0 != p0) begin
      miscompares++; $display("FAIL drop_pops: got %0d/%0d want 0/5", pops0 - p0, pops1 - p1);
    end
  endtask

  task automatic test_rule_thresh;
    clear_sb();
    cdp2um_tx_enable = 1'b1;
    cdp2um_rule_usedw = 5'd30;
    push_pkt(0, 40, 3, 4'd0, 1'b1);
    push_pkt(1, 41, 4, 4'd5, 1'b0);
    exp_drop++;
    wait_counts(100);
    repeat (5) @(negedge clk);
    vectors++;
    if (drop_pkt_cnt !== 32'(exp_drop)) begin miscompares++; $display("FAIL thr_drop: got %0d want %0d", drop_pkt_cnt, exp_drop); end
    vectors++;
    if (obs_grant.size() != 1 || obs_rule.size() != 0 || vq0.size() != 1 || pq0.size() != 3) begin
      miscompares++; $display("FAIL thr_hold: got grants %0d rules %0d vd0 %0d pkt0 %0d want 1 0 1 3",
        obs_grant.size(), obs_rule.size(), vq0.size(), pq0.size());
    end
    cdp2um_rule_usedw = 5'd29;
    exp_fwd++;
    wait_counts(100);
    vectors++;
    if (fwd_pkt_cnt !== 32'(exp_fwd)) begin miscompares++; $display("FAIL thr_fwd: got %0d want %0d", fwd_pkt_cnt, exp_fwd); end
    vectors++;
    if (obs_grant.size() != 2 || obs_grant[0] != 1 || obs_grant[1] != 0) begin
      miscompares++; $display("FAIL thr_order: got %0d grants want order 1,0", obs_grant.size());
    end
    vectors++;
    if (obs_rule.size() != 1 || obs_rule[0] !== exp_rule[0]) begin
      miscompares++; $display("FAIL thr_rule: got %0d rules want 1 of value %0d", obs_rule.size(), exp_rule[0]);
    end
    vectors++;
    if (obs_data.size() != exp_data.size()) begin
      miscompares++; $display("FAIL thr_data_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end else foreach (exp_data[i]) begin
      vectors++;
      if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL thr_word[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
    end
    cdp2um_rule_usedw = 5'd0;
  endtask

  task automatic test_tx_gap;
    logic [138:0] w[6];
    clear_sb();
    cdp2um_tx_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = mk(0, 50, i, 6, 4'd7);
      exp_data.push_back(w[i]);
    end
    for (int i = 0; i < 3; i++) pq0.push_back(w[i]);
    vq0.push_back(1'b1);
    for (int i = 0; i < 20 && obs_rule.size() == 0; i++) @(negedge clk);
    vectors++;
    if (obs_rule.size() != 1 || obs_rule[0] !== 30'd1) begin
      miscompares++; $display("FAIL gap_rule: got %0d rules want 1 of value 1", obs_rule.size());
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (obs_data.size() != 0 || pq0.size() != 3) begin
      miscompares++; $display("FAIL gap_wait_tx: got %0d words, %0d left want 0 words, 3 left", obs_data.size(), pq0.size());
    end
    cdp2um_tx_enable = 1'b1;
    for (int i = 0; i < 20 && pq0.size() != 0; i++) @(negedge clk);
    cdp2um_tx_enable = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 3; i < 6; i++) pq0.push_back(w[i]);
    exp_fwd++;
    wait_counts(100);
    vectors++;
    if (fwd_pkt_cnt !== 32'(exp_fwd)) begin miscompares++; $display("FAIL gap_fwd: got %0d want %0d", fwd_pkt_cnt, exp_fwd); end
    vectors++;
    if (obs_data.size() != 6) begin
      miscompares++; $display("FAIL gap_data_count: got %0d want 6", obs_data.size());
    end else begin
      foreach (exp_data[i]) begin
        vectors++;
        if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL gap_word[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
      end
      vectors++;
      if (obs_data_cyc[2] - obs_data_cyc[0] != 2 || obs_data_cyc[3] - obs_data_cyc[2] != 4 || obs_data_cyc[5] - obs_data_cyc[3] != 2) begin
        miscompares++; $display("FAIL gap_timing: got steps %0d %0d %0d want 2 4 2", obs_data_cyc[2] - obs_data_cyc[0],
          obs_data_cyc[3] - obs_data_cyc[2], obs_data_cyc[5] - obs_data_cyc[3]);
      end
    end
  endtask

  task automatic test_reset_mid;
    clear_sb();
    cdp2um_tx_enable = 1'b1;
    push_pkt(0, 60, 8, 4'd0, 1'b1);
    for (int i = 0; i < 50 && obs_data.size() < 2; i++) @(negedge clk);
    vectors++;
    if (obs_data.size() < 2) begin miscompares++; $display("FAIL rst_mid_start: got %0d words want >=2", obs_data.size()); end
    reset = 1'b0;
    pq0.delete(); pq1.delete(); vq0.delete(); vq1.delete();
    #1;
    vectors++;
    if ({um2cdp_rule_wrreq, um2cdp_data_valid, src0_pkt_rdreq, src1_pkt_rdreq} !== 4'b0 || um2cdp_data !== 139'b0 || um2cdp_rule !== 30'b0) begin
      miscompares++; $display("FAIL rst_mid_outputs: got strobes %b data %h rule %h want all 0",
        {um2cdp_rule_wrreq, um2cdp_data_valid, src0_pkt_rdreq, src1_pkt_rdreq}, um2cdp_data, um2cdp_rule);
    end
    vectors++;
    if (fwd_pkt_cnt !== 32'd0 || drop_pkt_cnt !== 32'd0) begin
      miscompares++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", fwd_pkt_cnt, drop_pkt_cnt);
    end
    @(negedge clk);
    vectors++;
    if (src0_pkt_rdreq !== 1'b0 || um2cdp_data_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_idle: got rdreq %b valid %b want 0 0", src0_pkt_rdreq, um2cdp_data_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    clear_sb();
    exp_fwd = 0; exp_drop = 0;
    push_pkt(0, 61, 3, 4'd9, 1'b1);
    exp_fwd = 1;
    wait_counts(100);
    vectors++;
    if (fwd_pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL rst_after_fwd: got %0d want 1", fwd_pkt_cnt); end
    vectors++;
    if (obs_rule.size() != 1 || obs_rule[0] !== 30'd1) begin
      miscompares++; $display("FAIL rst_after_rule: got %0d rules want 1 of value 1", obs_rule.size());
    end
    vectors++;
    if (obs_data.size() != exp_data.size()) begin
      miscompares++; $display("FAIL rst_after_data_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end else foreach (exp_data[i]) begin
      vectors++;
      if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL rst_after_word[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
    end
    vectors++;
    if (bad_pop != 0) begin miscompares++; $display("FAIL pop_on_empty: got %0d want 0", bad_pop); end
  endtask

  initial begin
    reset = 1'b0;
    cdp2um_rule_usedw = 5'd0;
    cdp2um_tx_enable = 1'b0;
    test_reset();
    test_single_fwd();
    test_round_robin();
    test_drop();
    test_rule_thresh();
    test_tx_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
